// File: rtl/mem_server_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_server_arbiter_pkg
// Shared types and constants for the memory-server arbiter slice.
//   CACHE_LINE_BYTES : default line size in bytes (data bus = 8x this)
//   ADDR_W           : address width of requester and downstream ports
//   mem_arb_state_t  : arbiter FSM states
//   rr_next          : round-robin successor of a requester index
// -----------------------------------------------------------------------------
package mem_server_arbiter_pkg;

  localparam int CACHE_LINE_BYTES = 64;
  localparam int ADDR_W           = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESPOND
  } mem_arb_state_t;

  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return (id + 1) % n;
  endfunction

endpackage

// File: rtl/mem_server_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_server_arbiter_if
// Bundles the requester-side and downstream-side signals of the arbiter.
//   Requester side : req_read_en, req_write_en, req_addr, req_data_i,
//                    req_data_en (in to arbiter), req_data_o, req_hit (out)
//   Downstream side: lower_addr, lower_data_i, lower_data_en, lower_read_en,
//                    lower_write_en (out of arbiter), lower_data_o, lower_hit (in)
//   Status         : grant_id, busy, timeout_err (out of arbiter)
// modport slave  : the arbiter's view
// modport master : the environment's view (requesters + backing memory)
// -----------------------------------------------------------------------------
interface mem_server_arbiter_if
  import mem_server_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LINE_BYTES = CACHE_LINE_BYTES
) ();

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int IDX_W  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_read_en;
  logic [NUM_REQ-1:0]            req_write_en;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ*LINE_W-1:0]     req_data_i;
  logic [NUM_REQ*LINE_BYTES-1:0] req_data_en;
  logic [LINE_W-1:0]             req_data_o;
  logic [NUM_REQ-1:0]            req_hit;

  logic [ADDR_W-1:0]             lower_addr;
  logic [LINE_W-1:0]             lower_data_i;
  logic [LINE_BYTES-1:0]         lower_data_en;
  logic                          lower_read_en;
  logic                          lower_write_en;
  logic [LINE_W-1:0]             lower_data_o;
  logic                          lower_hit;

  logic [IDX_W-1:0]              grant_id;
  logic                          busy;
  logic                          timeout_err;

  modport slave (
    input  req_read_en, req_write_en, req_addr, req_data_i, req_data_en,
    input  lower_data_o, lower_hit,
    output req_data_o, req_hit,
    output lower_addr, lower_data_i, lower_data_en, lower_read_en, lower_write_en,
    output grant_id, busy, timeout_err
  );

  modport master (
    output req_read_en, req_write_en, req_addr, req_data_i, req_data_en,
    output lower_data_o, lower_hit,
    input  req_data_o, req_hit,
    input  lower_addr, lower_data_i, lower_data_en, lower_read_en, lower_write_en,
    input  grant_id, busy, timeout_err
  );

endinterface

// File: rtl/mem_server_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: returns the first set bit of req_vec_i
// found by scanning upward from ptr_i and wrapping at N.
//   req_vec_i [N]      : request vector
//   ptr_i     [IDX_W]  : index with highest priority this cycle
//   valid_o            : any request present
//   idx_o     [IDX_W]  : chosen index (0 when valid_o is 0)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_vec_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Rotating the doubled vector puts requester (ptr+j)%N at bit j, so the
  // lowest set bit of rot is the round-robin winner.
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  assign dbl = {req_vec_i, req_vec_i} >> ptr_i;
  assign rot = dbl[N-1:0];

  always_comb begin
    int sum;
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = 0;
    // Descending scan so the smallest offset is assigned last and wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = int'(ptr_i) + j;
        if (sum >= N) sum = sum - N;
        valid_o = 1'b1;
        idx_o   = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/mem_server_arbiter.sv
// -----------------------------------------------------------------------------
// mem_server_arbiter
// Round-robin arbiter sharing one line-wide memory port among NUM_REQ
// requesters. One transaction at a time: IDLE -> ISSUE -> RESPOND -> IDLE.
// A watchdog aborts a downstream transaction that stays in ISSUE for
// TIMEOUT_CYCLES cycles (0 disables it).
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : mem_server_arbiter_if.slave (requester, downstream, status signals)
// All outputs are registered; busy is decoded straight from the state flop.
// -----------------------------------------------------------------------------
module mem_server_arbiter
  import mem_server_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int LINE_BYTES     = CACHE_LINE_BYTES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  mem_server_arbiter_if.slave bus
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int IDX_W  = $clog2(NUM_REQ);

  mem_arb_state_t        state_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      grant_q;
  logic [ADDR_W-1:0]     lower_addr_q;
  logic [LINE_W-1:0]     lower_data_q;
  logic [LINE_BYTES-1:0] lower_en_q;
  logic                  lower_rd_q;
  logic                  lower_wr_q;
  logic [LINE_W-1:0]     req_data_q;
  logic [NUM_REQ-1:0]    req_hit_q;
  logic                  timeout_q;

  logic [NUM_REQ-1:0]    req_vec;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [ADDR_W-1:0]     sel_addr;
  logic [LINE_W-1:0]     sel_data;
  logic [LINE_BYTES-1:0] sel_en;
  logic                  sel_wr;
  logic                  wdog_expire;

  assign req_vec = bus.req_read_en | bus.req_write_en;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .req_vec_i (req_vec),
    .ptr_i     (rr_ptr_q),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  // Unpack the winner's request fields. A request with both enables set is
  // forwarded as a write.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_en   = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr = bus.req_addr[ADDR_W*i +: ADDR_W];
        sel_data = bus.req_data_i[LINE_W*i +: LINE_W];
        sel_en   = bus.req_data_en[LINE_BYTES*i +: LINE_BYTES];
        sel_wr   = bus.req_write_en[i];
      end
    end
  end

  // Watchdog: holds 0 outside ISSUE, counts ISSUE cycles; expiry is flagged
  // on the TIMEOUT_CYCLES-th ISSUE edge.
  if (TIMEOUT_CYCLES > 0) begin : g_wdog
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;

    always_ff @(posedge clk) begin
      if (!reset || state_q != ARB_ISSUE) wdog_q <= '0;
      else                                wdog_q <= wdog_q + 1'b1;
    end

    assign wdog_expire = (state_q == ARB_ISSUE) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_wdog
    assign wdog_expire = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      lower_addr_q <= '0;
      lower_data_q <= '0;
      lower_en_q   <= '0;
      lower_rd_q   <= 1'b0;
      lower_wr_q   <= 1'b0;
      req_data_q   <= '0;
      req_hit_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_q      <= pick_idx;
            lower_addr_q <= sel_addr;
            lower_data_q <= sel_data;
            lower_en_q   <= sel_en;
            lower_wr_q   <= sel_wr;
            lower_rd_q   <= ~sel_wr;
            state_q      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // lower_hit beats a simultaneous watchdog expiry.
          if (bus.lower_hit || wdog_expire) begin
            lower_rd_q <= 1'b0;
            lower_wr_q <= 1'b0;
            req_data_q <= bus.lower_hit ? bus.lower_data_o : '0;
            req_hit_q  <= NUM_REQ'(1) << grant_q;
            timeout_q  <= ~bus.lower_hit;
            rr_ptr_q   <= IDX_W'(rr_next(32'(grant_q), NUM_REQ));
            state_q    <= ARB_RESPOND;
          end
        end
        ARB_RESPOND: begin
          req_hit_q <= '0;
          timeout_q <= 1'b0;
          state_q   <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.lower_addr     = lower_addr_q;
  assign bus.lower_data_i   = lower_data_q;
  assign bus.lower_data_en  = lower_en_q;
  assign bus.lower_read_en  = lower_rd_q;
  assign bus.lower_write_en = lower_wr_q;
  assign bus.req_data_o     = req_data_q;
  assign bus.req_hit        = req_hit_q;
  assign bus.grant_id       = grant_q;
  assign bus.busy           = (state_q != ARB_IDLE);
  assign bus.timeout_err    = timeout_q;

endmodule

// File: tb/tb_mem_server_arbiter.sv
module tb_mem_server_arbiter;
  import mem_server_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int LB = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_server_arbiter_if #(.NUM_REQ(NR), .LINE_BYTES(LB)) bus ();

  mem_server_arbiter #(.NUM_REQ(NR), .LINE_BYTES(LB), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vec  = 0;
  int miss = 0;

  // Environment knobs read by the backing-memory responder.
  int lat       = 5;
  bit never_hit = 1'b0;
  int stray_seq = 0;

  // Reference model state.
  bit          pend   [NR];
  bit          m_wr   [NR];
  logic [31:0] m_addr [NR];
  logic [31:0] m_data [NR];
  logic [3:0]  m_en   [NR];
  logic [31:0] ref_mem [256];
  int          ptr_m = 0;

  function automatic logic [31:0] pat(input int i);
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  // Backing memory: answers a held downstream request after lat cycles with
  // a one-cycle lower_hit; can be told never to answer or to emit a stray hit.
  initial begin
    logic [31:0] bmem [256];
    int rcnt, stray_done, ix;
    rcnt = 0; stray_done = 0;
    for (int i = 0; i < 256; i++) bmem[i] = pat(i);
    bus.lower_hit    = 1'b0;
    bus.lower_data_o = '0;
    forever begin
      @(negedge clk);
      if (bus.lower_hit) begin
        bus.lower_hit = 1'b0;
        rcnt = 0;
      end else if (stray_seq != stray_done) begin
        stray_done       = stray_seq;
        bus.lower_data_o = 32'hBAD0BAD0;
        bus.lower_hit    = 1'b1;
      end else if (!(bus.lower_read_en || bus.lower_write_en)) begin
        rcnt = 0;
      end else if (!never_hit) begin
        rcnt++;
        if (rcnt >= lat) begin
          ix = int'(bus.lower_addr[9:2]);
          bus.lower_data_o = bmem[ix];
          if (bus.lower_write_en)
            for (int b = 0; b < LB; b++)
              if (bus.lower_data_en[b]) bmem[ix][8*b +: 8] = bus.lower_data_i[8*b +: 8];
          bus.lower_hit = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // k: 0 read, 1 write, 2 both enables (treated as write)
  task automatic set_req(input int i, input int k, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] e);
    bus.req_read_en[i]  = (k != 1);
    bus.req_write_en[i] = (k != 0);
    bus.req_addr[32*i +: 32]  = a;
    bus.req_data_i[32*i +: 32] = d;
    bus.req_data_en[4*i +: 4]  = e;
    pend[i] = 1'b1; m_wr[i] = (k != 0); m_addr[i] = a; m_data[i] = d; m_en[i] = e;
  endtask

  task automatic drop(input int i);
    bus.req_read_en[i]  = 1'b0;
    bus.req_write_en[i] = 1'b0;
  endtask

  // Predict the next winner, follow its transaction to req_hit, check it,
  // retire it in the model. Returns on the negedge where req_hit is seen.
  task automatic step(input int want, input bit exp_to, input bit drop_mid);
    int w, c, cyc, t_en, ix;
    bit seen;
    w = -1;
    for (int j = 0; j < NR; j++) begin
      c = (ptr_m + j) % NR;
      if (w < 0 && pend[c]) w = c;
    end
    if (w < 0) begin
      vec++; miss++;
      $error("FAIL step_model: no pending requester");
      return;
    end
    cyc = 0; t_en = 0; seen = 1'b0;
    do begin
      @(negedge clk); cyc++;
      if (!seen && (bus.lower_read_en || bus.lower_write_en)) begin
        seen = 1'b1; t_en = cyc;
        chk("grant_id", 64'(bus.grant_id), 64'(w));
        chk("lower_addr", 64'(bus.lower_addr), 64'(m_addr[w]));
        chk("lower_write_en", 64'(bus.lower_write_en), 64'(m_wr[w]));
        chk("lower_read_en", 64'(bus.lower_read_en), 64'(!m_wr[w]));
        chk("lower_data_en", 64'(bus.lower_data_en), 64'(m_en[w]));
        chk("lower_data_i", 64'(bus.lower_data_i), 64'(m_data[w]));
        chk("busy_issue", 64'(bus.busy), 64'(1));
        if (drop_mid) drop(w);
      end
    end while (bus.req_hit == '0 && cyc < 100);
    chk("req_hit", 64'(bus.req_hit), 64'(1) << w);
    if (want >= 0) chk("grant_order", 64'(bus.grant_id), 64'(want));
    chk("lower_en_drop", 64'({bus.lower_read_en, bus.lower_write_en}), 64'(0));
    chk("timeout_err", 64'(bus.timeout_err), 64'(exp_to));
    chk("busy_respond", 64'(bus.busy), 64'(1));
    chk("latency", 64'(cyc - t_en), 64'(exp_to ? TO : lat));
    ix = int'(m_addr[w][9:2]);
    if (exp_to) chk("req_data_timeout", 64'(bus.req_data_o), 64'(0));
    else if (!m_wr[w]) chk("req_data", 64'(bus.req_data_o), 64'(ref_mem[ix]));
    else for (int b = 0; b < LB; b++)
      if (m_en[w][b]) ref_mem[ix][8*b +: 8] = m_data[w][8*b +: 8];
    ptr_m = (w + 1) % NR;
    pend[w] = 1'b0;
    drop(w);
  endtask

  initial begin
    int cyc, any;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    bus.req_read_en = '0; bus.req_write_en = '0; bus.req_addr = '0;
    bus.req_data_i = '0; bus.req_data_en = '0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_grant", 64'(bus.grant_id), 64'(0));
    chk("rst_req_hit", 64'(bus.req_hit), 64'(0));
    chk("rst_lower_en", 64'({bus.lower_read_en, bus.lower_write_en}), 64'(0));
    chk("rst_lower_addr", 64'(bus.lower_addr), 64'(0));
    chk("rst_timeout", 64'(bus.timeout_err), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Contention: all four read in the same cycle, pointer at 0
    lat = 5;
    set_req(0, 0, 32'h40, 32'h0, 4'hF);
    set_req(1, 0, 32'h80, 32'h0, 4'hF);
    set_req(2, 0, 32'hC0, 32'h0, 4'hF);
    set_req(3, 0, 32'h00, 32'h0, 4'hF);
    for (int k = 0; k < NR; k++) step(k, 1'b0, 1'b0);

    // Single read, latency 5
    set_req(0, 0, 32'h40, 32'h0, 4'hF);
    step(0, 1'b0, 1'b0);

    // Fairness: the served requester re-requests at once; grants alternate
    lat = 2;
    set_req(0, 0, 32'h04, 32'h0, 4'hF);
    set_req(2, 0, 32'h08, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      step((k % 2 == 0) ? 2 : 0, 1'b0, 1'b0);
      if (k < 3) begin
        if (k % 2 == 0) set_req(2, 0, 32'h08, 32'h0, 4'hF);
        else            set_req(0, 0, 32'h04, 32'h0, 4'hF);
      end
    end
    step(2, 1'b0, 1'b0);

    // Partial write then readback by another requester
    lat = 3;
    set_req(1, 1, 32'h100, 32'hDEADBEEF, 4'h1);
    step(1, 1'b0, 1'b0);
    set_req(3, 0, 32'h100, 32'h0, 4'h0);
    step(3, 1'b0, 1'b0);
    chk("wr_byte0", 64'(bus.req_data_o[7:0]), 64'(8'hEF));
    chk("wr_upper", 64'(bus.req_data_o[31:8]), 64'(pat(64) >> 8));

    // Downstream hit on the same edge as watchdog expiry; requester drops mid-ISSUE
    lat = TO;
    set_req(1, 0, 32'h0C, 32'h0, 4'hF);
    step(1, 1'b0, 1'b1);

    // Watchdog abort, then the next requester is served normally
    lat = 4;
    never_hit = 1'b1;
    set_req(2, 0, 32'h10, 32'h0, 4'hF);
    set_req(3, 0, 32'h14, 32'h0, 4'hF);
    step(2, 1'b1, 1'b0);
    never_hit = 1'b0;
    @(negedge clk);
    chk("timeout_pulse_end", 64'(bus.timeout_err), 64'(0));
    chk("req_hit_pulse_end", 64'(bus.req_hit), 64'(0));
    chk("busy_after_respond", 64'(bus.busy), 64'(0));
    step(3, 1'b0, 1'b0);

    // Stray downstream hit while idle is ignored
    @(negedge clk);
    stray_seq++;
    repeat (3) @(negedge clk);
    chk("stray_busy", 64'(bus.busy), 64'(0));
    chk("stray_req_hit", 64'(bus.req_hit), 64'(0));
    chk("stray_lower_en", 64'({bus.lower_read_en, bus.lower_write_en}), 64'(0));

    // Randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      any = 0;
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, int'($urandom_range(0, 2)), {26'(0), 4'($urandom_range(0, 15)), 2'b00},
                  $urandom, 4'($urandom_range(0, 15)));
      for (int i = 0; i < NR; i++) if (pend[i]) any = 1;
      if (any == 0) set_req(int'($urandom_range(0, NR - 1)), 0, 32'h20, 32'h0, 4'hF);
      lat = int'($urandom_range(1, 6));
      step(-1, 1'b0, 1'b0);
    end
    for (int n = 0; n < NR; n++) begin
      any = 0;
      for (int i = 0; i < NR; i++) if (pend[i]) any = 1;
      if (any != 0) step(-1, 1'b0, 1'b0);
    end

    // Reset in the middle of ISSUE
    lat = 3;
    set_req(1, 0, 32'h30, 32'h0, 4'hF);
    step(1, 1'b0, 1'b0);
    never_hit = 1'b1;
    set_req(3, 0, 32'h34, 32'h0, 4'hF);
    cyc = 0;
    while (!bus.lower_read_en && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rst_mid_grant", 64'(bus.grant_id), 64'(3));
    set_req(1, 0, 32'h38, 32'h0, 4'hF);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_lower_en", 64'({bus.lower_read_en, bus.lower_write_en}), 64'(0));
    chk("rst_mid_busy", 64'(bus.busy), 64'(0));
    chk("rst_mid_grant0", 64'(bus.grant_id), 64'(0));
    chk("rst_mid_req_hit", 64'(bus.req_hit), 64'(0));
    reset = 1'b1;
    never_hit = 1'b0;
    ptr_m = 0;
    step(1, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
